cal_r_mac: RTL and testbench

- Sequential producer of the Gram-Schmidt projection coefficient consumed by the v-update stage of the 4x4 QR MIMO detector.
- Computes R = (sum over k of conj(Q_k) * H_k) / SCALE for one column pair, streaming one complex element pair per beat through a single complex MAC.
- Sits upstream of the v-update stage. Its R output feeds that stage's R_real/R_imag inputs directly, with the same 28-bit signed, x1000 fixed-point convention.

---
 rtl/cal_pkg.sv | 21 ++
 rtl/cal_r_mac_if.sv | 23 ++
 rtl/complex_conj_multiply.sv | 15 +
 rtl/cal_r_mac.sv | 76 +++++++
 tb/tb_cal_r_mac.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cal_pkg.sv
// cal_pkg: shared widths, saturation bounds, FSM states and the divide/saturate
// helper for the Gram-Schmidt R coefficient path.
package cal_pkg;
   localparam int W      = 28;
   localparam int N_ELEM = 4;
   localparam int SCALE  = 1000;
   localparam int PROD_W = 2*W+1;
   localparam int ACC_W  = 2*W+3;
   localparam int CNT_W  = $clog2(N_ELEM+1);
   localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'(2**(W-1)-1);
   localparam logic signed [ACC_W-1:0] R_MIN = ACC_W'(-(2**(W-1)));

   typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} state_t;

   // signed '/' truncates toward zero, which is the rounding the v-update stage expects
   function automatic logic signed [W-1:0] div_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] q;
      q = a / ACC_W'(SCALE);
      return q > R_MAX ? R_MAX[W-1:0] : q < R_MIN ? R_MIN[W-1:0] : q[W-1:0];
   endfunction
endpackage

// File: rtl/cal_r_mac_if.sv
// cal_r_mac_if: element-pair input stream and R result stream of the R-coefficient MAC.
interface cal_r_mac_if;
   import cal_pkg::*;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] q_real;
   logic signed [W-1:0] q_imag;
   logic signed [W-1:0] h_real;
   logic signed [W-1:0] h_imag;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] r_real;
   logic signed [W-1:0] r_imag;

   modport master (
      output in_valid, q_real, q_imag, h_real, h_imag, out_ready,
      input  in_ready, out_valid, r_real, r_imag
   );
   modport slave (
      input  in_valid, q_real, q_imag, h_real, h_imag, out_ready,
      output in_ready, out_valid, r_real, r_imag
   );
endinterface

// File: rtl/complex_conj_multiply.sv
// complex_conj_multiply: conj(q) * h, combinational.
// One extra bit over 2W keeps q_real*h_real + q_imag*h_imag exact at the most negative corner.
module complex_conj_multiply
   import cal_pkg::*;
(
   input  logic signed [W-1:0]      q_real,
   input  logic signed [W-1:0]      q_imag,
   input  logic signed [W-1:0]      h_real,
   input  logic signed [W-1:0]      h_imag,
   output logic signed [PROD_W-1:0] pr,
   output logic signed [PROD_W-1:0] pi
);
   assign pr = PROD_W'(q_real) * PROD_W'(h_real) + PROD_W'(q_imag) * PROD_W'(h_imag);
   assign pi = PROD_W'(q_real) * PROD_W'(h_imag) - PROD_W'(q_imag) * PROD_W'(h_real);
endmodule

// File: rtl/cal_r_mac.sv
// cal_r_mac: streams N_ELEM (Q,H) pairs through one conjugate MAC and emits
// R = sum(conj(Q)*H)/SCALE, saturated to W bits, one vector at a time.
module cal_r_mac
   import cal_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   cal_r_mac_if.slave bus
);
   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic signed [ACC_W-1:0]  acc_r;
   logic signed [ACC_W-1:0]  acc_i;
   logic signed [PROD_W-1:0] pr;
   logic signed [PROD_W-1:0] pi;
   logic                     beat;

   complex_conj_multiply u_mul (
      .q_real(bus.q_real),
      .q_imag(bus.q_imag),
      .h_real(bus.h_real),
      .h_imag(bus.h_imag),
      .pr(pr),
      .pi(pi)
   );

   assign beat = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         acc_r         <= '0;
         acc_i         <= '0;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.r_real    <= '0;
         bus.r_imag    <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.in_ready <= 1'b1;
               if (beat) begin
                  acc_r <= ACC_W'(pr);
                  acc_i <= ACC_W'(pi);
                  cnt   <= CNT_W'(1);
                  state <= ACC;
               end
            end
            ACC: if (beat) begin
               acc_r <= acc_r + ACC_W'(pr);
               acc_i <= acc_i + ACC_W'(pi);
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N_ELEM-1)) begin
                  bus.in_ready <= 1'b0;
                  state        <= DIV;
               end
            end
            DIV: begin
               bus.r_real    <= div_sat(acc_r);
               bus.r_imag    <= div_sat(acc_i);
               bus.out_valid <= 1'b1;
               state         <= OUT;
            end
            OUT: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               acc_r         <= '0;
               acc_i         <= '0;
               cnt           <= '0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cal_r_mac.sv
// tb_cal_r_mac: table-driven vectors plus hand sequences for gaps, backpressure and mid-vector reset.
module tb_cal_r_mac;
   import cal_pkg::*;

   localparam int A = 134217727;
   localparam int B = -134217728;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cal_r_mac_if bus ();
   cal_r_mac dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic [N_ELEM-1:0][W-1:0] qr;
      logic [N_ELEM-1:0][W-1:0] qi;
      logic [N_ELEM-1:0][W-1:0] hr;
      logic [N_ELEM-1:0][W-1:0] hi;
      logic [W-1:0]             er;
      logic [W-1:0]             ei;
   } vec_t;

   vec_t tbl [5];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_el(input int i, input int k, input int qr, input int qi, input int hr, input int hi);
      tbl[i].qr[k] = W'(qr);
      tbl[i].qi[k] = W'(qi);
      tbl[i].hr[k] = W'(hr);
      tbl[i].hi[k] = W'(hi);
   endtask

   task automatic send(input logic [W-1:0] qr, input logic [W-1:0] qi, input logic [W-1:0] hr, input logic [W-1:0] hi);
      int b = 0;
      bus.in_valid = 1'b1;
      bus.q_real = qr;
      bus.q_imag = qi;
      bus.h_real = hr;
      bus.h_imag = hi;
      while (!bus.in_ready && b < 20) begin
         tick();
         b++;
      end
      if (!bus.in_ready) chk("send_timeout", 0, 1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int gap, input string nm);
      int c = 0;
      for (int k = 0; k < N_ELEM; k++) begin
         if (k > 0) repeat (gap) tick();
         send(v.qr[k], v.qi[k], v.hr[k], v.hi[k]);
      end
      chk({nm, "_valid_early"}, 32'(bus.out_valid), 0);
      while (!bus.out_valid && c < 10) begin
         tick();
         c++;
      end
      chk({nm, "_latency"}, c, 1);
      chk({nm, "_r_real"}, bus.r_real, $signed(v.er));
      chk({nm, "_r_imag"}, bus.r_imag, $signed(v.ei));
   endtask

   task automatic handshake(input string nm, input int er);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({nm, "_hs_out_valid"}, 32'(bus.out_valid), 0);
      chk({nm, "_hs_in_ready"}, 32'(bus.in_ready), 1);
      chk({nm, "_hs_r_hold"}, bus.r_real, er);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.q_real = '0;
      bus.q_imag = '0;
      bus.h_real = '0;
      bus.h_imag = '0;
      for (int i = 0; i < 5; i++) tbl[i] = '0;
      for (int k = 0; k < N_ELEM; k++) set_el(0, k, 1000, 0, 2*k+1, 2*k+2);
      tbl[0].er = W'(16);
      tbl[0].ei = W'(20);
      set_el(1, 0, 0, 1000, 1000, 0);
      tbl[1].er = W'(0);
      tbl[1].ei = W'(-1000);
      set_el(2, 0, 1, 0, -1999, 0);
      set_el(2, 1, 1, 0, 0, 999);
      tbl[2].er = W'(-1);
      tbl[2].ei = W'(0);
      for (int k = 0; k < N_ELEM; k++) set_el(3, k, A, B, A, B);
      tbl[3].er = W'(A);
      tbl[3].ei = W'(0);
      for (int k = 0; k < N_ELEM; k++) set_el(4, k, A, B, -A, A);
      tbl[4].er = W'(B);
      tbl[4].ei = W'(-536870);

      tick();
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_r_real", bus.r_real, 0);
      chk("rst_r_imag", bus.r_imag, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(bus.in_ready), 1);

      for (int i = 0; i < 5; i++) begin
         run_vec(tbl[i], 0, $sformatf("vec%0d", i));
         handshake($sformatf("vec%0d", i), $signed(tbl[i].er));
      end

      run_vec(tbl[0], 1, "gap1");
      handshake("gap1", 16);
      run_vec(tbl[0], 3, "gap3");
      handshake("gap3", 16);

      run_vec(tbl[2], 0, "bp");
      bus.in_valid = 1'b1;
      bus.q_real = W'(1000);
      bus.h_real = W'(1000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp%0d_out_valid", i), 32'(bus.out_valid), 1);
         chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 0);
         chk($sformatf("bp%0d_r_real", i), bus.r_real, -1);
         chk($sformatf("bp%0d_r_imag", i), bus.r_imag, 0);
      end
      bus.in_valid = 1'b0;
      handshake("bp", -1);
      run_vec(tbl[0], 0, "post_bp");
      handshake("post_bp", 16);

      send(tbl[3].qr[0], tbl[3].qi[0], tbl[3].hr[0], tbl[3].hi[0]);
      send(tbl[3].qr[1], tbl[3].qi[1], tbl[3].hr[1], tbl[3].hi[1]);
      rst_n = 1'b0;
      tick();
      chk("midrst_in_ready", 32'(bus.in_ready), 0);
      chk("midrst_out_valid", 32'(bus.out_valid), 0);
      rst_n = 1'b1;
      tick();
      chk("after_rst_in_ready", 32'(bus.in_ready), 1);
      chk("after_rst_out_valid", 32'(bus.out_valid), 0);
      run_vec(tbl[0], 0, "after_rst");
      handshake("after_rst", 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
